// File: rtl/sl_fifo_pkg.sv
// Shared definitions for the SL command/response FIFO pair.
// Holds the modifier encoding, word layout and error-flag bit indices
// used by both the host port and its response decoder.
package sl_fifo_pkg;

  localparam int WORD_W = 34;
  localparam int HMB    = 33;  // modifier high bit
  localparam int LMB    = 32;  // modifier low bit

  typedef enum logic [1:0] {
    MOD_CONFIG  = 2'd0,
    MOD_DATA    = 2'd1,
    MOD_STATUS  = 2'd2,
    MOD_CHANNEL = 2'd3
  } mod_e;

  localparam int ERR_ILLEGAL = 0;  // locally rejected host request
  localparam int ERR_PROTO   = 1;  // non-STATUS word where STATUS expected
  localparam int ERR_DATA_TX = 2;  // DATA response while mirror channel is TX

  typedef enum logic {C_IDLE, C_PUSH} cstate_e;

  typedef enum logic [1:0] {
    R_IDLE      = 2'd0,
    R_GAP       = 2'd1,
    R_WSTAT     = 2'd2,
    R_GAP_WSTAT = 2'd3
  } rstate_e;

endpackage

// File: rtl/sl_host_port_if.sv
// Host request handshake plus command/response FIFO signals.
// slave  : the sl_host_port side
// master : host logic / FIFO side (testbench)
interface sl_host_port_if;
  import sl_fifo_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [31:0]       req_data;
  logic              fifo_write_full;
  logic [WORD_W-1:0] fifo_write_data;
  logic              fifo_write_inc;
  logic              fifo_read_empty;
  logic [WORD_W-1:0] fifo_read_data;
  logic              fifo_read_inc;

  modport slave (
    input  req_valid, req_kind, req_data, fifo_write_full,
           fifo_read_empty, fifo_read_data,
    output req_ready, fifo_write_data, fifo_write_inc, fifo_read_inc
  );

  modport master (
    output req_valid, req_kind, req_data, fifo_write_full,
           fifo_read_empty, fifo_read_data,
    input  req_ready, fifo_write_data, fifo_write_inc, fifo_read_inc
  );
endinterface

// File: rtl/sl_resp_decoder.sv
// Response FIFO consumer: pops response words (at most one per two cycles)
// and keeps mirrors of the remote transceiver state.
// Ports: clk/rst_n; fifo_read_* FWFT response FIFO; mirror_* / rx_data*
// mirror outputs; err_proto_o / err_data_tx_o one-cycle error-set pulses.
module sl_resp_decoder
  import sl_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_read_empty_i,
  input  logic [WORD_W-1:0] fifo_read_data_i,
  output logic              fifo_read_inc_o,
  output logic              mirror_channel_o,
  output logic [15:0]       mirror_tx_config_o,
  output logic              mirror_tx_busy_o,
  output logic [15:0]       mirror_rx_config_o,
  output logic [15:0]       mirror_rx_status_o,
  output logic [15:0]       rx_data_o,
  output logic              rx_data_valid_o,
  output logic              err_proto_o,
  output logic              err_data_tx_o
);

  rstate_e     state_q, state_d;
  mod_e        kind;
  logic        pop, wstat_ok, decode;
  logic        chan_q;
  logic [15:0] tx_cfg_q, rx_cfg_q, rx_stat_q, rx_data_q;
  logic        tx_busy_q, rx_vld_q;
  logic        unused_hi;

  assign kind      = mod_e'(fifo_read_data_i[HMB:LMB]);
  assign unused_hi = ^fifo_read_data_i[31:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= R_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:      if (!fifo_read_empty_i)
                     state_d = (kind == MOD_DATA) ? R_GAP_WSTAT : R_GAP;
      R_GAP:       state_d = R_IDLE;
      R_GAP_WSTAT: state_d = R_WSTAT;
      R_WSTAT:     if (!fifo_read_empty_i)
                     state_d = (kind == MOD_DATA) ? R_GAP_WSTAT : R_GAP;
      default:     state_d = R_IDLE;
    endcase
  end

  // A STATUS word in R_WSTAT always lands in the RX status mirror; any other
  // word there is flagged but still decoded normally.
  always_comb begin
    pop           = !fifo_read_empty_i && (state_q == R_IDLE || state_q == R_WSTAT);
    wstat_ok      = pop && state_q == R_WSTAT && kind == MOD_STATUS;
    decode        = pop && !wstat_ok;
    err_proto_o   = pop && state_q == R_WSTAT && kind != MOD_STATUS;
    err_data_tx_o = decode && kind == MOD_DATA && !chan_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q    <= 1'b0;
      tx_cfg_q  <= '0;
      tx_busy_q <= 1'b0;
      rx_cfg_q  <= '0;
      rx_stat_q <= '0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
    end else begin
      rx_vld_q <= decode && kind == MOD_DATA;
      if (wstat_ok) rx_stat_q <= fifo_read_data_i[15:0];
      if (decode) begin
        case (kind)
          MOD_CHANNEL: chan_q <= fifo_read_data_i[0];
          MOD_CONFIG:  if (!chan_q) tx_cfg_q <= fifo_read_data_i[15:0];
                       else         rx_cfg_q <= fifo_read_data_i[15:0];
          MOD_STATUS:  if (!chan_q) tx_busy_q <= fifo_read_data_i[0];
                       else         rx_stat_q <= fifo_read_data_i[15:0];
          MOD_DATA:    rx_data_q <= fifo_read_data_i[15:0];
          default:     ;
        endcase
      end
    end
  end

  assign fifo_read_inc_o    = pop;
  assign mirror_channel_o   = chan_q;
  assign mirror_tx_config_o = tx_cfg_q;
  assign mirror_tx_busy_o   = tx_busy_q;
  assign mirror_rx_config_o = rx_cfg_q;
  assign mirror_rx_status_o = rx_stat_q;
  assign rx_data_o          = rx_data_q;
  assign rx_data_valid_o    = rx_vld_q;

endmodule

// File: rtl/sl_host_port.sv
// Host-side SL endpoint. Serializes host register requests into 34-bit
// {modifier, payload} command words and mirrors remote state from the
// response FIFO (via sl_resp_decoder). Command and response paths are
// fully independent.
// Ports: clk/rst_n; bus (request handshake + both FIFOs); local_channel;
// mirror_*; rx_data/rx_data_valid; sticky err_flags with err_clear.
module sl_host_port
  import sl_fifo_pkg::*;
#(
  parameter bit CHK_DATA_CH = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  sl_host_port_if.slave bus,
  output logic          local_channel,
  output logic          mirror_channel,
  output logic [15:0]   mirror_tx_config,
  output logic          mirror_tx_busy,
  output logic [15:0]   mirror_rx_config,
  output logic [15:0]   mirror_rx_status,
  output logic [15:0]   rx_data,
  output logic          rx_data_valid,
  output logic [2:0]    err_flags,
  input  logic          err_clear
);

  cstate_e           cstate_q, cstate_d;
  mod_e              rkind;
  logic              accept, drop;
  logic [WORD_W-1:0] wdata_q;
  logic              lchan_q;
  logic [2:0]        err_q, err_set;
  logic              err_proto, err_data_tx;

  assign rkind  = mod_e'(bus.req_kind);
  assign accept = bus.req_valid && bus.req_ready;
  assign drop   = rkind == MOD_STATUS ||
                  (CHK_DATA_CH && rkind == MOD_DATA && lchan_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cstate_q <= C_IDLE;
    else        cstate_q <= cstate_d;
  end

  always_comb begin
    cstate_d = cstate_q;
    case (cstate_q)
      C_IDLE:  if (accept && !drop) cstate_d = C_PUSH;
      C_PUSH:  if (!bus.fifo_write_full) cstate_d = C_IDLE;
      default: cstate_d = C_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = cstate_q == C_IDLE;
    bus.fifo_write_inc = cstate_q == C_PUSH && !bus.fifo_write_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= '0;
      lchan_q <= 1'b0;
    end else if (accept && !drop) begin
      wdata_q <= {bus.req_kind, bus.req_data};
      if (rkind == MOD_CHANNEL) lchan_q <= bus.req_data[0];
    end
  end

  // Set has priority over clear so an error in the clear cycle is not lost.
  always_comb begin
    err_set              = '0;
    err_set[ERR_ILLEGAL] = accept && drop;
    err_set[ERR_PROTO]   = err_proto;
    err_set[ERR_DATA_TX] = err_data_tx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= (err_clear ? 3'b000 : err_q) | err_set;
  end

  sl_resp_decoder u_resp (
    .clk                (clk),
    .rst_n              (rst_n),
    .fifo_read_empty_i  (bus.fifo_read_empty),
    .fifo_read_data_i   (bus.fifo_read_data),
    .fifo_read_inc_o    (bus.fifo_read_inc),
    .mirror_channel_o   (mirror_channel),
    .mirror_tx_config_o (mirror_tx_config),
    .mirror_tx_busy_o   (mirror_tx_busy),
    .mirror_rx_config_o (mirror_rx_config),
    .mirror_rx_status_o (mirror_rx_status),
    .rx_data_o          (rx_data),
    .rx_data_valid_o    (rx_data_valid),
    .err_proto_o        (err_proto),
    .err_data_tx_o      (err_data_tx)
  );

  assign bus.fifo_write_data = wdata_q;
  assign local_channel       = lchan_q;
  assign err_flags           = err_q;

endmodule
